sprite_draw_arbiter: RTL and testbench
======================================

# sprite_draw_arbiter

Shares the single VGA pixel-write port between several sprite sources: player, alien block, player bullet, alien bullet. Each source raises a request with a 4×4 sprite's top-left corner and colour. The arbiter grants one source at a time and emits that sprite's 16 pixel writes to the VGA adapter. It then acknowledges completion and moves to the next requester. It sits between the game-object modules and the VGA adapter, and it replaces the per-object free-running pixel counters.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- SPR_DIM_LOG2, 2, log2 of sprite edge; sprite is 2^SPR_DIM_LOG2 square (4×4)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester draw request, level, held until done
- req_x  in  N_REQ*8  packed top-left x per requester, slice i = [8i+7:8i]
- req_y  in  N_REQ*7  packed top-left y per requester
- req_colour  in  N_REQ*3  packed colour per requester
- grant  out  N_REQ  one-hot; high for the whole draw of the granted requester
- done  out  N_REQ  one-cycle pulse to the granted requester after its last pixel
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y to VGA adapter
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write enable to VGA adapter
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - If any req bit is high at the clock edge, the arbiter selects a winner and moves to DRAW.
  - It latches the winner's x, y and colour into base registers, sets grant to the one-hot winner and clears the pixel counter to 0.
  - If no req bit is high, it stays in IDLE.
- DRAW:
  - Pixel counter pc has width 2*SPR_DIM_LOG2.
  - Outputs: vga_x = base_x + pc[SPR_DIM_LOG2-1:0]; vga_y = base_y + pc[2*SPR_DIM_LOG2-1:SPR_DIM_LOG2]; vga_colour = base colour.
  - pc increments every cycle.
  - When pc is at its maximum (15), the next state is DONE.
  - req_x, req_y and req_colour changes during DRAW are ignored.
- Arithmetic: the sums are computed at 9 bits for x and 8 bits for y. vga_plot is high only if the sum is < 160 (x) and < 120 (y); off-screen pixels are skipped (vga_plot low) but still consume a cycle. vga_x and vga_y carry the sum truncated to port width.
- DONE:
  - done[winner] is high for one cycle; grant stays asserted during DONE and vga_plot is low.
  - Next state is always IDLE; grant clears on entering IDLE.
- Requester rule: on seeing done, the requester drops req by the following edge. The arbiter does not sample req in DONE.
- Requests are re-evaluated only in IDLE, so the winner cannot be pre-empted mid-sprite.
- A req that drops during DRAW does not abort the draw; the sprite completes and done still pulses.
- Reset, at any time including mid-draw: state IDLE, grant=0, done=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, pc=0, round-robin pointer=0, base registers=0.

## Timing
- Latency: req high before edge k → grant and first pixel (pc=0) valid in cycle k..k+1.
- Draw duration: 16 cycles of DRAW followed by 1 cycle of DONE, 17 cycles in total. Next grant is no earlier than 2 cycles after DONE: one IDLE cycle, then the arbitration edge.
- Worst-case service for one requester with all N_REQ requesters continuously active: (N_REQ-1)*18 cycles (round-robin build).
- All outputs are registered or decoded directly from registered state; no input-to-output combinational path.

## Configuration
- SPRITE_DRAW_RR_EN defined:
  - Round-robin arbitration. The pointer is set to winner+1 (mod N_REQ) on each grant.
  - Search starts at the pointer and wraps around.
- Undefined:
  - Fixed priority: lowest index wins. Index 0 is the player.
  - No pointer register.

## Structure
- Shared package space_inv_pkg:
  - SCREEN_W=160, SCREEN_H=120
  - X_W=8, Y_W=7, COLOUR_W=3
  - Enum draw_state_t {IDLE, DRAW, DONE}
  - Colour constants WHITE=3'b111, BLACK=3'b000
- One sub-module, draw_req_arbiter:
  - Combinational winner selection from req plus pointer.
  - Contains the SPRITE_DRAW_RR_EN conditional and the pointer register.
  - FSM, pixel counter and clipping stay in the top module.

## Test plan
- Single request:
  - Stimulus: req[0]=1 at (78,100), colour 7.
  - Response: 16 consecutive plots covering x 78..81 and y 100..103, x varying fastest. done[0] pulses in cycle 17; busy falls after.
- Right-edge clip:
  - Stimulus: req[1] at (158,50).
  - Response: plots only for x 158,159, i.e. 8 plot cycles. The draw still takes 16 cycles; done[1] pulses.
- Contention, round-robin build:
  - Stimulus: req=4'b1111 held, each requester re-requesting immediately after its done.
  - Response: grant order 0,1,2,3,0. Fixed-priority build: 0,0,0…
- Reset during draw:
  - Stimulus: assert reset_n=0 at pc=7.
  - Response: all outputs 0 immediately (asynchronous). After release with req[2]=1, the draw restarts at pc=0 with grant[2].
- Mid-draw input change:
  - Stimulus: change req_x[0] and drop req[0] during DRAW.
  - Response: pixels use the latched coordinates; all 16 cycles complete; done[0] still pulses.

Source files
------------

// File: rtl/space_inv_pkg.sv
// Shared types and constants for the space-invaders video path.
package space_inv_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;
    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } sprite_req_t;

endpackage

// File: rtl/sprite_draw_arbiter_if.sv
// Sprite requester bus plus the VGA pixel-write port driven by the arbiter.
interface sprite_draw_arbiter_if import space_inv_pkg::*; #(
    parameter int unsigned N_REQ = 4
) ();

    logic [N_REQ-1:0]          req;
    logic [N_REQ*X_W-1:0]      req_x;
    logic [N_REQ*Y_W-1:0]      req_y;
    logic [N_REQ*COLOUR_W-1:0] req_colour;
    logic [N_REQ-1:0]          grant;
    logic [N_REQ-1:0]          done;
    logic [X_W-1:0]            vga_x;
    logic [Y_W-1:0]            vga_y;
    logic [COLOUR_W-1:0]       vga_colour;
    logic                      vga_plot;
    logic                      busy;

    modport master (
        output req, req_x, req_y, req_colour,
        input  grant, done, vga_x, vga_y, vga_colour, vga_plot, busy
    );

    modport slave (
        input  req, req_x, req_y, req_colour,
        output grant, done, vga_x, vga_y, vga_colour, vga_plot, busy
    );

endinterface

// File: rtl/sprite_draw_arbiter_arb.sv
// Winner selection for sprite draw requests.
// SPRITE_DRAW_RR_EN selects round-robin; otherwise lowest index wins.
module draw_req_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             idle,
    output logic             any_c,
    output logic [IDX_W-1:0] winner_c,
    output logic [N_REQ-1:0] winner_oh_c
);

    assign any_c       = |req;
    assign winner_oh_c = any_c ? (N_REQ'(1) << winner_c) : '0;

`ifdef SPRITE_DRAW_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_c;
    logic             found_c;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        idx_c    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx_c = IDX_W'((32'(ptr_q) + i) % N_REQ);
            if (!found_c && req[idx_c]) begin
                found_c  = 1'b1;
                winner_c = idx_c;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (idle && any_c) begin
            ptr_d = (winner_c == IDX_W'(N_REQ - 1)) ? '0 : winner_c + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`else
    logic found_c;
    logic unused_c;

    assign unused_c = ^{clk, reset_n, idle};

    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found_c && req[i]) begin
                found_c  = 1'b1;
                winner_c = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Shares the VGA pixel-write port between sprite sources, drawing one 4x4 sprite per grant.
// Arbitration policy is set in draw_req_arbiter by SPRITE_DRAW_RR_EN.
module sprite_draw_arbiter import space_inv_pkg::*; #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned SPR_DIM_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sprite_draw_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PC_W  = 2 * SPR_DIM_LOG2;

    draw_state_t          state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    sprite_req_t          base_q, base_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic [X_W-1:0]       vga_x_q, vga_x_d;
    logic [Y_W-1:0]       vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]  vga_colour_q, vga_colour_d;
    logic                 vga_plot_q, vga_plot_d;
    logic                 busy_q, busy_d;

    logic                 any_c;
    logic [IDX_W-1:0]     winner_c;
    logic [N_REQ-1:0]     winner_oh_c;
    sprite_req_t          reqs_c [N_REQ];
    logic [X_W:0]         x_sum_c;
    logic [Y_W:0]         y_sum_c;

    draw_req_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (bus.req),
        .idle        (state_q == IDLE),
        .any_c       (any_c),
        .winner_c    (winner_c),
        .winner_oh_c (winner_oh_c)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            reqs_c[i].x      = bus.req_x[i*X_W +: X_W];
            reqs_c[i].y      = bus.req_y[i*Y_W +: Y_W];
            reqs_c[i].colour = bus.req_colour[i*COLOUR_W +: COLOUR_W];
        end
    end

    // Request inputs are only looked at in IDLE, so a draw cannot be pre-empted.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        base_d  = base_q;
        grant_d = grant_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    state_d = DRAW;
                    pc_d    = '0;
                    base_d  = reqs_c[winner_c];
                    grant_d = winner_oh_c;
                end
            end
            DRAW: begin
                pc_d = pc_q + PC_W'(1);
                if (pc_q == '1) begin
                    state_d = DONE;
                    done_d  = grant_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Pixel outputs are registered from the next base/counter so they line up with DRAW.
    always_comb begin
        x_sum_c      = {1'b0, base_d.x} + (X_W+1)'(pc_d[SPR_DIM_LOG2-1:0]);
        y_sum_c      = {1'b0, base_d.y} + (Y_W+1)'(pc_d[PC_W-1:SPR_DIM_LOG2]);
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        busy_d       = (state_d != IDLE);
        if (state_d == DRAW) begin
            vga_x_d      = x_sum_c[X_W-1:0];
            vga_y_d      = y_sum_c[Y_W-1:0];
            vga_colour_d = base_d.colour;
            vga_plot_d   = (x_sum_c < (X_W+1)'(SCREEN_W)) && (y_sum_c < (Y_W+1)'(SCREEN_H));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            base_q       <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= BLACK;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            base_q       <= base_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Randomized bench for sprite_draw_arbiter against a transaction-level sprite model.
// Follows the arbitration policy selected by SPRITE_DRAW_RR_EN.
module tb_sprite_draw_arbiter;

    localparam int N    = 4;
    localparam int DIM  = 4;
    localparam int NPIX = DIM * DIM;

    logic clk = 1'b0;
    logic reset_n;

    sprite_draw_arbiter_if #(.N_REQ(N)) bus ();

    sprite_draw_arbiter #(
        .N_REQ        (N),
        .SPR_DIM_LOG2 (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           rx [N];
    int           ry [N];
    int           rc [N];
    logic [N-1:0] req_v;
    int           ptr_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        bus.req = req_v;
        for (int i = 0; i < N; i++) begin
            bus.req_x[8*i +: 8]      = 8'(rx[i]);
            bus.req_y[7*i +: 7]      = 7'(ry[i]);
            bus.req_colour[3*i +: 3] = 3'(rc[i]);
        end
    endtask

    task automatic rand_coords(input int i);
        rx[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
        ry[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
        rc[i] = $urandom_range(0, 7);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"},  32'(bus.grant),      0);
        check_eq({tag, "_done"},   32'(bus.done),       0);
        check_eq({tag, "_x"},      32'(bus.vga_x),      0);
        check_eq({tag, "_y"},      32'(bus.vga_y),      0);
        check_eq({tag, "_colour"}, 32'(bus.vga_colour), 0);
        check_eq({tag, "_plot"},   32'(bus.vga_plot),   0);
        check_eq({tag, "_busy"},   32'(bus.busy),       0);
    endtask

    // One arbitration opportunity from IDLE; optionally scrambles inputs mid-draw or resets at abort_pc.
    task automatic run_sprite(input logic [N-1:0] pat, input bit mutate, input int abort_pc);
        int w, bx, by, bc, px, py;
        w     = -1;
        req_v = pat;
        drive();
`ifdef SPRITE_DRAW_RR_EN
        for (int i = 0; i < N; i++)
            if (w < 0 && pat[(ptr_m + i) % N]) w = (ptr_m + i) % N;
        if (w >= 0) ptr_m = (w + 1) % N;
`else
        for (int i = 0; i < N; i++)
            if (w < 0 && pat[i]) w = i;
`endif
        tick();
        if (w < 0) begin
            check_eq("idle_busy",  32'(bus.busy),     0);
            check_eq("idle_grant", 32'(bus.grant),    0);
            check_eq("idle_plot",  32'(bus.vga_plot), 0);
            return;
        end
        bx = rx[w];
        by = ry[w];
        bc = rc[w];
        for (int pc = 0; pc < NPIX; pc++) begin
            px = bx + pc % DIM;
            py = by + pc / DIM;
            check_eq("draw_grant",  32'(bus.grant),      32'(1 << w));
            check_eq("draw_busy",   32'(bus.busy),       1);
            check_eq("draw_done",   32'(bus.done),       0);
            check_eq("draw_plot",   32'(bus.vga_plot),   32'(px < 160 && py < 120));
            check_eq("draw_x",      32'(bus.vga_x),      32'(px % 256));
            check_eq("draw_y",      32'(bus.vga_y),      32'(py % 128));
            check_eq("draw_colour", 32'(bus.vga_colour), 32'(bc));
            if (pc == abort_pc) begin
                reset_n = 1'b0;
                #1;
                check_all_zero("async_rst");
                ptr_m = 0;
                req_v = '0;
                drive();
                repeat (2) @(posedge clk);
                #3;
                reset_n = 1'b1;
                return;
            end
            if (mutate) begin
                for (int i = 0; i < N; i++) rand_coords(i);
                req_v[$urandom_range(0, N - 1)] = 1'($urandom_range(0, 1));
                req_v[w] = 1'b0;
                drive();
            end
            tick();
        end
        check_eq("done_pulse", 32'(bus.done),     32'(1 << w));
        check_eq("done_grant", 32'(bus.grant),    32'(1 << w));
        check_eq("done_plot",  32'(bus.vga_plot), 0);
        check_eq("done_busy",  32'(bus.busy),     1);
        req_v[w] = 1'b0;
        drive();
        tick();
        check_eq("post_busy",  32'(bus.busy),  0);
        check_eq("post_grant", 32'(bus.grant), 0);
        check_eq("post_done",  32'(bus.done),  0);
    endtask

    initial begin
        reset_n = 1'b0;
        ptr_m   = 0;
        req_v   = '0;
        for (int i = 0; i < N; i++) begin
            rx[i] = 10 * i;
            ry[i] = 5 * i;
            rc[i] = i;
        end
        drive();
        #23;
        check_all_zero("reset");
        reset_n = 1'b1;

        // All requesters continuously active.
        repeat (5) run_sprite('1, 1'b0, -1);

        rx[0] = 78;  ry[0] = 100; rc[0] = 7;
        run_sprite(4'b0001, 1'b0, -1);

        rx[1] = 158; ry[1] = 50;  rc[1] = 3;
        run_sprite(4'b0010, 1'b0, -1);

        rx[0] = 20;  ry[0] = 30;  rc[0] = 5;
        run_sprite(4'b0001, 1'b1, -1);

        rx[2] = 40;  ry[2] = 60;  rc[2] = 6;
        run_sprite(4'b0100, 1'b0, 7);
        run_sprite(4'b0100, 1'b0, -1);

        run_sprite(4'b0000, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) rand_coords(i);
            run_sprite(N'($urandom_range(0, (1 << N) - 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
